digit_serial_adder: RTL
=======================

# digit_serial_adder

Parametrised, multi-cycle, digit-serial two's-complement adder for the datapath. It accepts WIDTH-bit operands through a valid/ready handshake and adds them DIGIT bits per cycle, least-significant digit first, keeping the carry in a register between digits. It returns the sum, carry-out and signed overflow through a second valid/ready handshake. It is the area-reduced replacement for a full-width ripple adder in the ALU, where result latency can be traded for gate count.

## Interface
- WIDTH, 16: operand and result width in bits; must be ≥1.
- DIGIT, 4: bits added per cycle; 1 ≤ DIGIT ≤ WIDTH; WIDTH % DIGIT == 0, otherwise elaboration fails.
- Derived: NDIG = WIDTH/DIGIT.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  unit can accept operands; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry-in; acts as borrow-in when sub=1.
- sub  in  1  subtract select; port exists only with ADDER_SUB_EN.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  result.
- c_out  out  1  carry out of the MSB.
- ovf  out  1  signed overflow flag.

## Operation
- FSM states and transitions:
  - IDLE → RUN on in_valid && in_ready.
  - RUN → DONE after the digit counter reaches NDIG-1.
  - DONE → IDLE on out_valid && out_ready.
- On accept:
  - Latch a into a shift register.
  - Latch b into a second shift register, as ~b when sub=1.
  - Carry register = c_in ^ sub.
  - Digit counter = 0.
- Each RUN cycle:
  - Add the low DIGIT bits of both shift registers and the carry.
  - Shift the result digit into sum from the MSB end.
  - Shift the operand registers right by DIGIT.
  - Store the digit carry-out and increment the counter.
- Final digit:
  - c_out = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Subtraction with c_in=0 gives a−b; with c_in=1 it gives a−b−1. c_out is the raw carry, so 1 means no borrow.
- in_ready = (state==IDLE) and out_valid = (state==DONE), both decoded directly from state registers.
- sum, c_out and ovf:
  - stable and valid while out_valid is high;
  - keep their last value after the handshake;
  - may change during RUN while the result is being built.
- Inputs are ignored outside IDLE.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, ovf=0, counter and carry 0.
- Latency: accept at edge E0; out_valid rises after edge E_NDIG.
- Initiation interval: NDIG+2 cycles with out_ready held high.
- NDIG=1 (DIGIT==WIDTH): one RUN cycle.
- Backpressure: DONE holds indefinitely; outputs frozen; in_ready stays 0.
- Reset asserted mid-RUN or in DONE: immediate return to reset values. The partial result is discarded and no out_valid is issued.
- There is no simultaneous accept and deliver; the two handshakes are mutually exclusive by state.

## Configuration
- ADDER_SUB_EN defined:
  - sub port present;
  - b is inverted at capture;
  - carry seed is c_in ^ sub.
- ADDER_SUB_EN undefined:
  - sub port absent;
  - behaviour equals sub=0, with carry seed c_in;
  - no inversion logic is synthesised.

## Structure
- Shared package adder_pkg:
  - state enum typedef {IDLE, RUN, DONE};
  - helper function computing NDIG and the counter width ($clog2(NDIG), minimum 1).
- Sub-module digit_adder:
  - combinational DIGIT-bit ripple chain built from the team's 1-bit full-adder cells;
  - exposes sum digit, carry-out and carry into the top bit, for the ovf calculation.
- Top level contains the FSM, counter, shift registers and carry register.

## Test plan
All cases use WIDTH=16 and DIGIT=4.
- a=0x1234, b=0x4321, c_in=0 → sum=0x5555, c_out=0, ovf=0; out_valid exactly 4 cycles after accept.
- a=0xFFFF, b=0x0001 → sum=0x0000, c_out=1, ovf=0. a=0x7FFF, b=0x0001 → sum=0x8000, c_out=0, ovf=1.
- With ADDER_SUB_EN: sub=1, a=0x0005, b=0x0007, c_in=0 → sum=0xFFFE, c_out=0. Same operands with c_in=1 → 0xFFFD.
- out_ready held low 5 cycles after out_valid:
  - out_valid stays 1, sum stays constant, in_ready stays 0;
  - raising out_ready → in_ready=1 next cycle.
- rst_n pulsed low 2 cycles into RUN:
  - out_valid=0, sum=0, in_ready=1 immediately;
  - the next operation (0x0001+0x0001) yields 0x0002 with no stale carry.
- DIGIT=16 build: 0x8000+0x8000 → sum=0x0000, c_out=1, ovf=1, out_valid 1 cycle after accept.

Source files
------------

// File: rtl/digit_serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
// Optional subtract support is selected with the ADDER_SUB_EN macro.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-digit adder still needs a one-bit counter.
    function automatic int calc_cnt_w(input int ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Operand and result handshakes of the digit-serial adder.
// The sub signal exists only when ADDER_SUB_EN is defined.
interface digit_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

`ifdef ADDER_SUB_EN
    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );
    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
`else
    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );
    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
`endif

endinterface

// File: rtl/digit_serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder built from 1-bit full-adder cells.
// Also exposes the carry into its top bit so the caller can form signed overflow.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ctop
);
    logic [DIGIT:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar g = 0; g < DIGIT; g++) begin : g_cell
        full_adder u_fa (
            .i_a   (i_a[g]),
            .i_b   (i_b[g]),
            .i_cin (w_c[g]),
            .o_s   (o_sum[g]),
            .o_cout(w_c[g+1])
        );
    end

    assign o_cout = w_c[DIGIT];
    assign o_ctop = w_c[DIGIT-1];
endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial two's-complement adder: DIGIT bits per cycle, LSD first.
// Define ADDER_SUB_EN to add the sub port (b inverted at capture, carry seed c_in ^ sub).
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    digit_serial_adder_if.slave  bus
);
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("digit_serial_adder: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
    end

    localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int CNT_W = calc_cnt_w(NDIG);
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [WIDTH-1:0]       r_sum;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_carry;
    logic                   r_cout;
    logic                   r_ovf;

    logic [WIDTH-1:0]       w_b_cap;
    logic                   w_seed;
    logic                   w_accept;
    logic                   w_deliver;
    logic                   w_last;
    logic [DIGIT-1:0]       w_dsum;
    logic                   w_dcout;
    logic                   w_dctop;
    logic [WIDTH+DIGIT-1:0] w_sum_cat;

`ifdef ADDER_SUB_EN
    assign w_b_cap = bus.sub ? ~bus.b : bus.b;
    assign w_seed  = bus.c_in ^ bus.sub;
`else
    assign w_b_cap = bus.b;
    assign w_seed  = bus.c_in;
`endif

    assign w_accept  = bus.in_valid && (r_state == IDLE);
    assign w_deliver = bus.out_ready && (r_state == DONE);
    assign w_last    = (r_state == RUN) && (r_cnt == LAST_DIG);

    // New digit enters at the MSB end; the slice also works when NDIG == 1.
    assign w_sum_cat = {w_dsum, r_sum};

    digit_adder #(
        .DIGIT(DIGIT)
    ) u_digit (
        .i_a   (r_a[DIGIT-1:0]),
        .i_b   (r_b[DIGIT-1:0]),
        .i_cin (r_carry),
        .o_sum (w_dsum),
        .o_cout(w_dcout),
        .o_ctop(w_dctop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (w_deliver) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // c_out/ovf track every digit; only the final digit's values survive into DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= w_b_cap;
            r_carry <= w_seed;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_sum   <= w_sum_cat[WIDTH+DIGIT-1:DIGIT];
            r_carry <= w_dcout;
            r_cout  <= w_dcout;
            r_ovf   <= w_dcout ^ w_dctop;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.sum       = r_sum;
    assign bus.c_out     = r_cout;
    assign bus.ovf       = r_ovf;

endmodule
